// File: rtl/fwft_fifo_wc_pkg.sv
// Shared helpers for the FWFT FIFO family: lane-width derivation and
// modulo-depth address stepping.
package fwft_fifo_wc_pkg;

  function automatic int out_width(input int in_w, input int ratio);
    return in_w / ratio;
  endfunction

  // Index width that never collapses to zero bits, even for ratio=1.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned inc_mod(input int unsigned v, input int unsigned modulus);
    return (v >= modulus - 1) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/fwft_fifo_wc_if.sv
// Source/sink bundle for fwft_fifo_wc; master drives requests and data,
// slave (the FIFO) returns flags, the current lane and the fill level.
interface fwft_fifo_wc_if #(
  parameter int in_width = 32,
  parameter int ratio    = 4,
  parameter int widthad  = 3
);
  import fwft_fifo_wc_pkg::*;

  localparam int out_w = out_width(in_width, ratio);
  localparam int uw    = widthad + $clog2(ratio) + 1;

  logic                write_en;
  logic [in_width-1:0] write_data;
  logic                full;
  logic                almost_full;
  logic                read_en;
  logic [out_w-1:0]    read_data;
  logic                empty;
  logic                almost_empty;
  logic [uw-1:0]       usedw;

  modport master (
    output write_en, write_data, read_en,
    input  full, almost_full, empty, almost_empty, read_data, usedw
  );

  modport slave (
    input  write_en, write_data, read_en,
    output full, almost_full, empty, almost_empty, read_data, usedw
  );
endinterface

// File: rtl/lutram_dual_port_fifo.sv
// Simple dual-port distributed RAM: synchronous write on port a,
// asynchronous read on port b.
module lutram_dual_port_fifo #(
  parameter int width    = 32,
  parameter int numwords = 8,
  parameter int widthad  = 3
) (
  input  logic               clk,
  input  logic               wren_a,
  input  logic [widthad-1:0] address_a,
  input  logic [width-1:0]   data_a,
  input  logic [widthad-1:0] address_b,
  output logic [width-1:0]   q_b
);
  logic [width-1:0] mem_q [numwords];

  // NOTE: storage is deliberately not reset; occupancy flags gate its contents.
  // NOTE: clocked state uses non-blocking assignment so readers see pre-edge values.
  always_ff @(posedge clk) begin
    if (wren_a) mem_q[address_a] <= data_a;
  end

  assign q_b = mem_q[address_b];
endmodule

// File: rtl/fwft_fifo_wc.sv
// First-word-fall-through FIFO that stores wide words and presents them as
// `ratio` narrow lanes, with flush and clock-enable gating.
module fwft_fifo_wc
  import fwft_fifo_wc_pkg::*;
#(
  parameter int    in_width           = 32,
  parameter int    ratio              = 4,
  parameter int    depth              = 8,
  parameter int    widthad            = 3,
  parameter int    lsb_first          = 1,
  parameter int    almost_empty_value = 2,
  parameter int    almost_full_value  = 2,
  parameter string name               = ""
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clken,
  input  logic          flush,
  fwft_fifo_wc_if.slave bus
);
  localparam int out_w       = out_width(in_width, ratio);
  localparam int lane_w      = clog2_min1(ratio);
  localparam int cnt_w       = widthad + 1;
  localparam int uw          = widthad + $clog2(ratio) + 1;
  localparam int stall_limit = 1_000_000;

  if (ratio < 1 || depth < 1 || widthad < 1 || (in_width % ratio) != 0 || widthad < $clog2(depth)) begin : g_bad_params
    $fatal(1, "fwft_fifo_wc %s: illegal parameters (in_width %0d, ratio %0d, depth %0d, widthad %0d)",
           name, in_width, ratio, depth, widthad);
  end

  logic [widthad-1:0]  wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
  logic [lane_w-1:0]   lane_q, lane_d;
  logic [cnt_w-1:0]    count_q, count_d;
  logic [uw-1:0]       usedw_q, usedw_d;
  logic                empty_q, empty_d, full_q, full_d;
  logic                wr_hs, rd_hs, last, freed;
  logic [in_width-1:0] word;

  // Flush drops any concurrent transfer, so it masks both handshakes.
  assign wr_hs = clken & ~flush & bus.write_en & ~full_q;
  assign rd_hs = clken & ~flush & bus.read_en & ~empty_q;
  assign last  = (lane_q == lane_w'(ratio - 1));
  assign freed = rd_hs & last;

  always_comb begin
    // NOTE: every comb output gets a default first, so no path infers a latch.
    wr_addr_d = wr_addr_q;
    rd_addr_d = rd_addr_q;
    lane_d    = lane_q;
    count_d   = count_q;
    if (clken && flush) begin
      wr_addr_d = '0;
      rd_addr_d = '0;
      lane_d    = '0;
      count_d   = '0;
    end else begin
      if (wr_hs) wr_addr_d = widthad'(inc_mod(32'(wr_addr_q), depth));
      if (rd_hs) begin
        if (last) begin
          lane_d    = '0;
          rd_addr_d = widthad'(inc_mod(32'(rd_addr_q), depth));
        end else begin
          lane_d = lane_q + 1'b1;
        end
      end
      case ({wr_hs, freed})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
    usedw_d = uw'(count_d) * uw'(ratio) - uw'(lane_d);
    empty_d = (count_d == '0);
    full_d  = (count_d == cnt_w'(depth));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_addr_q <= '0;
      rd_addr_q <= '0;
      lane_q    <= '0;
      count_q   <= '0;
      usedw_q   <= '0;
      empty_q   <= 1'b1;
      full_q    <= 1'b0;
    end else begin
      wr_addr_q <= wr_addr_d;
      rd_addr_q <= rd_addr_d;
      lane_q    <= lane_d;
      count_q   <= count_d;
      usedw_q   <= usedw_d;
      empty_q   <= empty_d;
      full_q    <= full_d;
    end
  end

  lutram_dual_port_fifo #(
    .width   (in_width),
    .numwords(depth),
    .widthad (widthad)
  ) u_mem (
    .clk      (clk),
    .wren_a   (wr_hs),
    .address_a(wr_addr_q),
    .data_a   (bus.write_data),
    .address_b(rd_addr_q),
    .q_b      (word)
  );

  // Lane order within a word is reversed when the MSB lane goes first.
  logic [out_w-1:0]  lanes [ratio];
  logic [lane_w-1:0] sel;

  for (genvar g = 0; g < ratio; g++) begin : g_lane
    assign lanes[g] = word[g*out_w +: out_w];
  end

  assign sel              = (lsb_first != 0) ? lane_q : lane_w'(ratio - 1) - lane_q;
  assign bus.read_data    = lanes[sel];
  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.usedw        = usedw_q;
  assign bus.almost_full  = (count_q >= cnt_w'(almost_full_value));
  assign bus.almost_empty = (usedw_q <= uw'(almost_empty_value));

  // Simulation-only watchdogs: long stalls and pointer/count consistency.
  logic        stall;
  logic [19:0] stall_cnt_q;

  assign stall = (bus.write_en & full_q) | (bus.read_en & empty_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) stall_cnt_q <= '0;
    else if (!stall || stall_cnt_q == 20'(stall_limit - 1)) stall_cnt_q <= '0;
    else stall_cnt_q <= stall_cnt_q + 1'b1;
  end

  a_stall_warn: assert property (@(posedge clk) disable iff (!reset_n)
    !(stall && stall_cnt_q == 20'(stall_limit - 1)))
    else $warning("fwft_fifo_wc %s: 1000000 consecutive cycles of write-while-full or read-while-empty", name);

  a_ptr_consistent: assert property (@(posedge clk) disable iff (!reset_n)
    ((32'(rd_addr_q) + 32'(count_q)) % depth) == 32'(wr_addr_q))
    else $fatal(1, "fwft_fifo_wc %s: rd_addr + count does not match wr_addr", name);

  a_count_range: assert property (@(posedge clk) disable iff (!reset_n)
    count_q <= cnt_w'(depth))
    else $fatal(1, "fwft_fifo_wc %s: count exceeds depth", name);
endmodule

// File: tb/tb_fwft_fifo_wc.sv
// Scoreboard bench for fwft_fifo_wc: three configurations (32/4/4 LSB-first,
// 16/2/3 streaming across wrap, 32/4/4 MSB-first), lanes checked by monitors.
module tb_fwft_fifo_wc;
  logic clk = 1'b0;
  logic reset_n;
  logic clken;
  logic flush;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0] qa[$];
  logic [7:0] qb[$];
  logic [7:0] qc[$];

  always #5 clk = ~clk;

  fwft_fifo_wc_if #(.in_width(32), .ratio(4), .widthad(2)) a_if ();
  fwft_fifo_wc_if #(.in_width(16), .ratio(2), .widthad(2)) b_if ();
  fwft_fifo_wc_if #(.in_width(32), .ratio(4), .widthad(2)) c_if ();

  fwft_fifo_wc #(.in_width(32), .ratio(4), .depth(4), .widthad(2), .lsb_first(1),
                 .almost_empty_value(2), .almost_full_value(2), .name("dut_a"))
    u_dut_a (.clk(clk), .reset_n(reset_n), .clken(clken), .flush(flush), .bus(a_if));

  fwft_fifo_wc #(.in_width(16), .ratio(2), .depth(3), .widthad(2), .lsb_first(1),
                 .almost_empty_value(2), .almost_full_value(2), .name("dut_b"))
    u_dut_b (.clk(clk), .reset_n(reset_n), .clken(clken), .flush(1'b0), .bus(b_if));

  fwft_fifo_wc #(.in_width(32), .ratio(4), .depth(4), .widthad(2), .lsb_first(0),
                 .almost_empty_value(2), .almost_full_value(2), .name("dut_c"))
    u_dut_c (.clk(clk), .reset_n(reset_n), .clken(clken), .flush(1'b0), .bus(c_if));

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_a(input logic [31:0] w);
    for (int l = 0; l < 4; l++) qa.push_back(w[l*8 +: 8]);
  endtask

  // Monitors: a lane is consumed at the next edge whenever read_en meets ~empty.
  always @(negedge clk) begin
    if (reset_n && clken && !flush && a_if.read_en && !a_if.empty) begin
      if (qa.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL a_lane: got 0x%0h with nothing expected at %0t", a_if.read_data, $time);
      end else check("a_lane", 32'(a_if.read_data), 32'(qa.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (reset_n && clken && b_if.read_en && !b_if.empty) begin
      if (qb.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL b_lane: got 0x%0h with nothing expected at %0t", b_if.read_data, $time);
      end else check("b_lane", 32'(b_if.read_data), 32'(qb.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (reset_n && clken && c_if.read_en && !c_if.empty) begin
      if (qc.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL c_lane: got 0x%0h with nothing expected at %0t", c_if.read_data, $time);
      end else check("c_lane", 32'(c_if.read_data), 32'(qc.pop_front()));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] words [4];
    int wk, rd;
    words = '{32'h13121110, 32'h23222120, 32'h33323130, 32'h43424140};

    reset_n = 1'b0; clken = 1'b1; flush = 1'b0;
    a_if.write_en = 1'b0; a_if.read_en = 1'b0; a_if.write_data = '0;
    b_if.write_en = 1'b0; b_if.read_en = 1'b0; b_if.write_data = '0;
    c_if.write_en = 1'b0; c_if.read_en = 1'b0; c_if.write_data = '0;
    #22 reset_n = 1'b1;
    cyc();

    check("rst_empty", 32'(a_if.empty), 32'd1);
    check("rst_full", 32'(a_if.full), 32'd0);
    check("rst_usedw", 32'(a_if.usedw), 32'd0);
    check("rst_almost_empty", 32'(a_if.almost_empty), 32'd1);
    check("rst_almost_full", 32'(a_if.almost_full), 32'd0);
    check("rst_b_empty", 32'(b_if.empty), 32'd1);

    // Single word, no pass-through, lanes LSB first.
    a_if.write_en = 1'b1; a_if.write_data = 32'hDDCCBBAA; push_a(32'hDDCCBBAA);
    check("no_passthrough", 32'(a_if.empty), 32'd1);
    cyc();
    a_if.write_en = 1'b0;
    check("first_empty", 32'(a_if.empty), 32'd0);
    check("first_data", 32'(a_if.read_data), 32'h000000AA);
    a_if.read_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_usedw", 32'(a_if.usedw), 32'(4 - i));
      check("drain_almost_empty", 32'(a_if.almost_empty), 32'((4 - i) <= 2));
      cyc();
    end
    a_if.read_en = 1'b0;
    check("drain_empty", 32'(a_if.empty), 32'd1);

    // Fill to full, refused write, refused write alongside the freeing read.
    a_if.write_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("fill_almost_full", 32'(a_if.almost_full), 32'(i >= 2));
      a_if.write_data = words[i]; push_a(words[i]);
      cyc();
    end
    check("fill_full", 32'(a_if.full), 32'd1);
    check("fill_usedw", 32'(a_if.usedw), 32'd16);
    a_if.write_data = 32'hBAD00BAD;
    cyc();
    a_if.write_en = 1'b0;
    check("refused_full", 32'(a_if.full), 32'd1);
    check("refused_usedw", 32'(a_if.usedw), 32'd16);
    a_if.read_en = 1'b1;
    repeat (3) cyc();
    check("partial_full", 32'(a_if.full), 32'd1);
    check("partial_usedw", 32'(a_if.usedw), 32'd13);
    a_if.write_en = 1'b1; a_if.write_data = 32'hEEEEEEEE;
    cyc();
    a_if.write_en = 1'b0;
    check("free_full", 32'(a_if.full), 32'd0);
    check("free_usedw", 32'(a_if.usedw), 32'd12);
    repeat (11) cyc();
    check("last_lane_usedw", 32'(a_if.usedw), 32'd1);
    a_if.write_en = 1'b1; a_if.write_data = 32'h44332211; push_a(32'h44332211);
    cyc();
    a_if.write_en = 1'b0;
    check("swap_empty", 32'(a_if.empty), 32'd0);
    check("swap_usedw", 32'(a_if.usedw), 32'd4);
    repeat (4) cyc();
    a_if.read_en = 1'b0;
    check("swap_drained", 32'(a_if.empty), 32'd1);

    // Flush with two words held and a concurrent write.
    a_if.write_en = 1'b1; a_if.write_data = 32'h11111111;
    cyc();
    a_if.write_data = 32'h22222222;
    cyc();
    check("preflush_usedw", 32'(a_if.usedw), 32'd8);
    flush = 1'b1; a_if.write_data = 32'h33333333;
    cyc();
    flush = 1'b0; a_if.write_en = 1'b0;
    check("flush_empty", 32'(a_if.empty), 32'd1);
    check("flush_usedw", 32'(a_if.usedw), 32'd0);
    check("flush_full", 32'(a_if.full), 32'd0);
    a_if.write_en = 1'b1; a_if.write_data = 32'h0D0C0B0A; push_a(32'h0D0C0B0A);
    cyc();
    a_if.write_en = 1'b0; a_if.read_en = 1'b1;
    repeat (4) cyc();
    a_if.read_en = 1'b0;

    // Clock enable low: held requests and flush change nothing.
    a_if.write_en = 1'b1; a_if.write_data = 32'h5A6B7C8D; push_a(32'h5A6B7C8D);
    cyc();
    clken = 1'b0; a_if.read_en = 1'b1; a_if.write_data = 32'hFFFF0000;
    repeat (3) cyc();
    flush = 1'b1;
    cyc();
    check("clken_usedw", 32'(a_if.usedw), 32'd4);
    check("clken_empty", 32'(a_if.empty), 32'd0);
    check("clken_data", 32'(a_if.read_data), 32'h0000008D);
    flush = 1'b0; a_if.write_en = 1'b0; clken = 1'b1;
    repeat (4) cyc();
    a_if.read_en = 1'b0;
    check("clken_drained", 32'(a_if.empty), 32'd1);

    // Asynchronous reset mid-burst, between clock edges.
    a_if.write_en = 1'b1; a_if.write_data = 32'h77777777;
    cyc();
    a_if.write_data = 32'h88888888;
    #3 reset_n = 1'b0;
    #1 check("async_rst_empty", 32'(a_if.empty), 32'd1);
    check("async_rst_usedw", 32'(a_if.usedw), 32'd0);
    #1 reset_n = 1'b1; a_if.write_en = 1'b0;
    cyc();
    check("post_rst_empty", 32'(a_if.empty), 32'd1);

    // Streaming through depth 3 with random gaps on both sides.
    wk = 0; rd = 0;
    for (int t = 0; t < 400 && rd < 20; t++) begin
      b_if.write_en   = (wk < 10) && ($urandom_range(0, 2) != 0);
      b_if.write_data = {8'(2*wk + 1), 8'(2*wk)};
      b_if.read_en    = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      if (b_if.write_en && !b_if.full) begin
        qb.push_back(8'(2*wk)); qb.push_back(8'(2*wk + 1));
        wk++;
      end
      if (b_if.read_en && !b_if.empty) rd++;
      cyc();
    end
    b_if.write_en = 1'b0; b_if.read_en = 1'b0;
    check("b_lanes_read", 32'(rd), 32'd20);
    check("b_end_empty", 32'(b_if.empty), 32'd1);

    // MSB-first lane order.
    c_if.write_en = 1'b1; c_if.write_data = 32'hDDCCBBAA;
    qc.push_back(8'hDD); qc.push_back(8'hCC); qc.push_back(8'hBB); qc.push_back(8'hAA);
    cyc();
    c_if.write_en = 1'b0; c_if.read_en = 1'b1;
    repeat (4) cyc();
    c_if.read_en = 1'b0;
    check("c_end_empty", 32'(c_if.empty), 32'd1);

    check("a_queue_left", 32'(qa.size()), 32'd0);
    check("b_queue_left", 32'(qb.size()), 32'd0);
    check("c_queue_left", 32'(qc.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
